// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and constants for the MIPS hazard/forwarding
//                logic: forward-select encoding and scoreboard entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Widest register address / readiness index a scoreboard entry can hold.
    localparam int SB_AW_MAX = 8;
    localparam int SB_RDY_W  = 8;

    localparam int FWD_RF = 0;

    function automatic int FWD_STAGE(input int s);
        return s + 1;
    endfunction

    typedef struct packed {
        logic                valid;
        logic                wr;
        logic [SB_AW_MAX-1:0] rw;
        logic [SB_RDY_W-1:0]  rdy;
    } sbEntry_t;

endpackage
`default_nettype wire

// File: rtl/hz_match.sv
`default_nettype none
// ============================================================================
//  Module      : hz_match
//  Description : Youngest-producer search over the scoreboard for one source
//                operand; yields hit, forward select and not-ready flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module hz_match
    import core_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int AW    = 5,
    parameter int FW    = $clog2(DEPTH + 1)
) (
    input  sbEntry_t [DEPTH-1:0] sb,
    input  logic [AW-1:0]        addr,
    input  logic                 used,
    input  logic [FW-1:0]        loStage,
    input  logic                 slack,
    output logic                 hit,
    output logic [FW-1:0]        sel,
    output logic                 notReady
);

    logic w_srcValid;

    assign w_srcValid = used && (addr != '0);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit      = 1'b0;
        sel      = FW'(FWD_RF);
        notReady = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (w_srcValid && (s >= int'(loStage)) && sb[s].valid && sb[s].wr &&
                (sb[s].rw == SB_AW_MAX'(addr))) begin
                hit      = 1'b1;
                sel      = (s >= int'(sb[s].rdy)) ? FW'(FWD_STAGE(s)) : FW'(FWD_RF);
                notReady = (s + int'(slack)) < int'(sb[s].rdy);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_unit
//  Description : Scoreboard-based stall/bubble/flush and forwarding control
//                for ID-stage branch and EX-stage ALU consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
    import core_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int AW       = 5,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 32,
    parameter int FW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_wr,
    input  logic [AW-1:0]    id_rw,
    input  logic             id_is_load,
    input  logic             id_is_branch,
    input  logic             br_taken,
    output logic             stall,
    output logic             bubble,
    output logic             if_flush,
    output logic [FW-1:0]    id_fwd_a,
    output logic [FW-1:0]    id_fwd_b,
    output logic [FW-1:0]    ex_fwd_a,
    output logic [FW-1:0]    ex_fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    sbEntry_t [DEPTH-1:0] r_sb;
    logic [AW-1:0]        r_exRs;
    logic [AW-1:0]        r_exRt;
    logic                 r_exRsUsed;
    logic                 r_exRtUsed;
    logic [CNT_W-1:0]     r_stallCnt;

    logic                 w_idAHit, w_idANr, w_idBHit, w_idBNr;
    logic                 w_exAHit, w_exANr, w_exBHit, w_exBNr;
    logic [FW-1:0]        w_idASel, w_idBSel, w_exASel, w_exBSel;
    logic                 w_stall;
    logic                 w_slackId;
    sbEntry_t             w_idEntry;
    logic                 w_unusedEx;

    // Branches consume operands in ID, one stage earlier than ALU ops.
    assign w_slackId = ~id_is_branch;

    hz_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_idA (
        .sb       (r_sb),
        .addr     (id_rs),
        .used     (id_rs_used),
        .loStage  (FW'(0)),
        .slack    (w_slackId),
        .hit      (w_idAHit),
        .sel      (w_idASel),
        .notReady (w_idANr)
    );

    hz_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_idB (
        .sb       (r_sb),
        .addr     (id_rt),
        .used     (id_rt_used),
        .loStage  (FW'(0)),
        .slack    (w_slackId),
        .hit      (w_idBHit),
        .sel      (w_idBSel),
        .notReady (w_idBNr)
    );

    // Stage 0 is the EX instruction itself, so EX searches start at MEM.
    hz_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_exA (
        .sb       (r_sb),
        .addr     (r_exRs),
        .used     (r_exRsUsed),
        .loStage  (FW'(1)),
        .slack    (1'b0),
        .hit      (w_exAHit),
        .sel      (w_exASel),
        .notReady (w_exANr)
    );

    hz_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_exB (
        .sb       (r_sb),
        .addr     (r_exRt),
        .used     (r_exRtUsed),
        .loStage  (FW'(1)),
        .slack    (1'b0),
        .hit      (w_exBHit),
        .sel      (w_exBSel),
        .notReady (w_exBNr)
    );

    assign w_unusedEx = &{1'b0, w_exAHit, w_exANr, w_exBHit, w_exBNr};

    // Outputs are forced low while reset is held, independent of ID inputs.
    assign w_stall  = rst & id_valid & ((w_idAHit & w_idANr) | (w_idBHit & w_idBNr));
    assign stall    = w_stall;
    assign bubble   = w_stall;
    assign if_flush = rst & id_valid & id_is_branch & br_taken & ~w_stall;
    assign id_fwd_a = rst ? w_idASel : FW'(FWD_RF);
    assign id_fwd_b = rst ? w_idBSel : FW'(FWD_RF);
    assign ex_fwd_a = rst ? w_exASel : FW'(FWD_RF);
    assign ex_fwd_b = rst ? w_exBSel : FW'(FWD_RF);
    assign stall_cnt = r_stallCnt;

    always_comb begin
        w_idEntry       = '0;
        w_idEntry.valid = id_valid;
        w_idEntry.wr    = id_wr;
        w_idEntry.rw    = SB_AW_MAX'(id_rw);
        w_idEntry.rdy   = id_is_load ? SB_RDY_W'(LOAD_RDY) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb       <= '0;
            r_exRs     <= '0;
            r_exRt     <= '0;
            r_exRsUsed <= 1'b0;
            r_exRtUsed <= 1'b0;
            r_stallCnt <= '0;
        end else begin
            for (int s = 1; s < DEPTH; s++) begin
                r_sb[s] <= r_sb[s-1];
            end
            r_sb[0] <= w_stall ? sbEntry_t'('0) : w_idEntry;

            if (w_stall) begin
                r_exRsUsed <= 1'b0;
                r_exRtUsed <= 1'b0;
            end else begin
                r_exRs     <= id_rs;
                r_exRt     <= id_rt;
                r_exRsUsed <= id_rs_used;
                r_exRtUsed <= id_rt_used;
            end

            if (w_stall && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_fwd_unit
//  Description : Directed plus randomized check of hazard_fwd_unit against an
//                instruction-level pipeline model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_unit;

    localparam int DEPTH    = 3;
    localparam int AW       = 5;
    localparam int LOAD_RDY = 2;
    localparam int CNT_W    = 4;
    localparam int FW       = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_rs_used, id_rt_used, id_wr;
    logic             id_is_load, id_is_branch, br_taken;
    logic [AW-1:0]    id_rs, id_rt, id_rw;
    logic             stall, bubble, if_flush;
    logic [FW-1:0]    id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_fwd_unit #(
        .DEPTH(DEPTH), .AW(AW), .LOAD_RDY(LOAD_RDY), .CNT_W(CNT_W), .FW(FW)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wr(id_wr), .id_rw(id_rw), .id_is_load(id_is_load),
        .id_is_branch(id_is_branch), .br_taken(br_taken),
        .stall(stall), .bubble(bubble), .if_flush(if_flush),
        .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit v; bit wr; bit ld; bit br; bit tk;
        int rw; int rs; int rt; bit rsU; bit rtU;
    } ins_t;

    typedef struct { bit v; bit wr; bit ld; int rw; } slot_t;

    int    checks = 0;
    int    errors = 0;
    slot_t pipe [DEPTH];
    int    exRs, exRt;
    bit    exRsU, exRtU;
    int    mCnt;
    bit    mStall;
    ins_t  cur;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t nop();
        ins_t i = '{default: 0};
        return i;
    endfunction
    function automatic ins_t alu(input int rd, input int rs, input int rt);
        ins_t i = '{default: 0};
        i.v = 1; i.wr = 1; i.rw = rd; i.rs = rs; i.rt = rt; i.rsU = 1; i.rtU = 1;
        return i;
    endfunction
    function automatic ins_t lw(input int rt, input int base);
        ins_t i = '{default: 0};
        i.v = 1; i.wr = 1; i.ld = 1; i.rw = rt; i.rs = base; i.rsU = 1;
        return i;
    endfunction
    function automatic ins_t beq(input int rs, input int rt, input bit tk);
        ins_t i = '{default: 0};
        i.v = 1; i.br = 1; i.tk = tk; i.rs = rs; i.rt = rt; i.rsU = 1; i.rtU = 1;
        return i;
    endfunction

    // Cycles after leaving ID before a producer's value exists.
    function automatic int readyAt(input int s);
        return pipe[s].ld ? LOAD_RDY : 0;
    endfunction
    function automatic int youngest(input int r, input bit used, input int lo);
        if (!used || r == 0) return -1;
        for (int s = lo; s < DEPTH; s++)
            if (pipe[s].v && pipe[s].wr && pipe[s].rw == r) return s;
        return -1;
    endfunction
    function automatic int fwdOf(input int s);
        return (s >= 0 && s >= readyAt(s)) ? s + 1 : 0;
    endfunction
    function automatic bit lateOf(input int s, input bit br);
        if (s < 0) return 0;
        return br ? (s < readyAt(s)) : (s + 1 < readyAt(s));
    endfunction

    task automatic modelReset();
        for (int s = 0; s < DEPTH; s++) pipe[s] = '{0, 0, 0, 0};
        exRs = 0; exRt = 0; exRsU = 0; exRtU = 0; mCnt = 0; mStall = 0;
    endtask

    task automatic compare();
        int sa, sb, ea, eb;
        if (!rst) modelReset();
        sa = youngest(cur.rs, cur.rsU, 0);
        sb = youngest(cur.rt, cur.rtU, 0);
        ea = youngest(exRs, exRsU, 1);
        eb = youngest(exRt, exRtU, 1);
        mStall = rst && cur.v && (lateOf(sa, cur.br) || lateOf(sb, cur.br));
        chk("stall", stall, mStall);
        chk("bubble", bubble, mStall);
        chk("if_flush", if_flush, rst && cur.v && cur.br && cur.tk && !mStall);
        chk("id_fwd_a", id_fwd_a, rst ? fwdOf(sa) : 0);
        chk("id_fwd_b", id_fwd_b, rst ? fwdOf(sb) : 0);
        chk("ex_fwd_a", ex_fwd_a, rst ? fwdOf(ea) : 0);
        chk("ex_fwd_b", ex_fwd_b, rst ? fwdOf(eb) : 0);
        chk("stall_cnt", stall_cnt, mCnt);
    endtask

    task automatic modelClock();
        if (!rst) begin
            modelReset();
            return;
        end
        if (mStall) mCnt = (mCnt == CNT_MAX) ? CNT_MAX : mCnt + 1;
        for (int s = DEPTH - 1; s > 0; s--) pipe[s] = pipe[s-1];
        if (mStall) begin
            pipe[0] = '{0, 0, 0, 0};
            exRsU = 0; exRtU = 0;
        end else begin
            pipe[0] = '{cur.v, cur.wr, cur.ld, cur.rw};
            exRs = cur.rs; exRt = cur.rt; exRsU = cur.rsU; exRtU = cur.rtU;
        end
    endtask

    task automatic drive(input ins_t i);
        cur          = i;
        id_valid     = i.v;
        id_rs        = AW'(i.rs);
        id_rt        = AW'(i.rt);
        id_rs_used   = i.rsU;
        id_rt_used   = i.rtU;
        id_wr        = i.wr;
        id_rw        = AW'(i.rw);
        id_is_load   = i.ld;
        id_is_branch = i.br;
        br_taken     = i.tk;
    endtask

    task automatic present(input ins_t i);
        drive(i);
        #4;
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        modelClock();
        #1;
    endtask

    initial begin
        ins_t r;
        modelReset();
        rst = 1'b0;
        drive(nop());
        #2;
        compare();
        chk("reset stall_cnt", stall_cnt, 0);
        chk("reset stall", stall, 0);
        tick();
        rst = 1'b1;

        // Back-to-back ALU dependency forwards from MEM.
        present(alu(3, 1, 2)); tick();
        present(alu(4, 3, 1)); chk("t1 stall", stall, 0); tick();
        present(nop());        chk("t1 ex_fwd_a", ex_fwd_a, 2); tick();

        // Load-use: one stall, then WB forward on both operands.
        present(lw(5, 0)); tick();
        present(alu(6, 5, 5)); chk("t2 stall", stall, 1); chk("t2 bubble", bubble, 1); tick();
        present(alu(6, 5, 5)); chk("t2 stall released", stall, 0); tick();
        present(nop()); chk("t2 ex_fwd_a", ex_fwd_a, 3); chk("t2 ex_fwd_b", ex_fwd_b, 3);
        chk("t2 stall_cnt", stall_cnt, 1); tick();

        // Branch consumers in ID.
        present(alu(7, 1, 2)); tick();
        present(beq(7, 0, 0)); chk("t3 stall", stall, 0); chk("t3 id_fwd_a", id_fwd_a, 1); tick();
        present(lw(8, 0)); tick();
        present(beq(8, 0, 0)); chk("t3 stall c1", stall, 1); tick();
        present(beq(8, 0, 0)); chk("t3 stall c2", stall, 1); tick();
        present(beq(8, 0, 0)); chk("t3 stall c3", stall, 0); chk("t3 id_fwd_a wb", id_fwd_a, 3); tick();

        // Writes to r0 never create a dependency.
        begin
            r = alu(0, 0, 0); r.rtU = 0;
            present(r); tick();
        end
        present(alu(1, 0, 0)); chk("t4 stall", stall, 0);
        chk("t4 id_fwd_a", id_fwd_a, 0); chk("t4 id_fwd_b", id_fwd_b, 0); tick();
        present(nop()); tick();

        // Taken branch flush, and flush held off by a stall.
        present(beq(9, 10, 1)); chk("t5 if_flush", if_flush, 1); tick();
        present(nop()); chk("t5 if_flush off", if_flush, 0); tick();
        present(lw(11, 0)); tick();
        present(beq(11, 0, 1)); chk("t5 flush blocked 1", if_flush, 0); tick();
        present(beq(11, 0, 1)); chk("t5 flush blocked 2", if_flush, 0); tick();
        present(beq(11, 0, 1)); chk("t5 flush after", if_flush, 1); chk("t5 stall", stall, 0); tick();

        // Asynchronous reset in the middle of a load-use stall.
        present(lw(12, 0)); tick();
        present(alu(13, 12, 0)); chk("t6 stall", stall, 1); chk("t6 cnt before", stall_cnt, 5);
        #1 rst = 1'b0;
        #1 compare();
        chk("t6 stall in reset", stall, 0); chk("t6 cnt in reset", stall_cnt, 0);
        tick();
        rst = 1'b1;
        present(alu(13, 12, 0)); chk("t6 after release", stall, 0); tick();

        // Randomized traffic over a small register set to force hazards.
        for (int n = 0; n < 3000; n++) begin
            r = '{default: 0};
            r.v   = ($urandom_range(0, 3) != 0);
            r.rs  = $urandom_range(0, 3);
            r.rt  = $urandom_range(0, 3);
            r.rw  = $urandom_range(0, 3);
            r.rsU = $urandom_range(0, 1);
            r.rtU = $urandom_range(0, 1);
            r.wr  = $urandom_range(0, 1);
            r.ld  = r.wr && ($urandom_range(0, 2) == 0);
            r.br  = !r.wr && $urandom_range(0, 1);
            r.tk  = $urandom_range(0, 1);
            rst   = ($urandom_range(0, 149) != 0);
            present(r);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard and forwarding controller for the pipelined MIPS core. It is the next-generation replacement for the separate load-use, branch-flush and forwarding-select logic, and sits beside the ID stage. The block tracks every in-flight register write across DEPTH post-ID stages in its own scoreboard. From that scoreboard it produces stall, bubble, IF-flush and forwarding selects for both ID-stage (branch compare) and EX-stage (ALU) consumers, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- DEPTH, 3, number of tracked stages after ID (0 = EX, 1 = MEM, 2 = WB, …)
- AW, 5, register address width
- LOAD_RDY, 2, first stage index at which load data is forwardable
- CNT_W, 32, stall counter width
- FW, $clog2(DEPTH+1), forwarding-select width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  AW  source register addresses
- id_rs_used, id_rt_used  in  1  source is actually read
- id_wr  in  1  instruction writes the register file
- id_rw  in  AW  destination register
- id_is_load  in  1  result comes from data memory
- id_is_branch  in  1  needs operands in ID
- br_taken  in  1  branch resolved taken in ID
- stall  out  1  hold PC and IF/ID
- bubble  out  1  inject NOP into ID/EX
- if_flush  out  1  invalidate IF/ID
- id_fwd_a, id_fwd_b  out  FW  ID operand select
- ex_fwd_a, ex_fwd_b  out  FW  EX operand select
- stall_cnt  out  CNT_W  stall cycles since reset

## Operation
- Scoreboard entry per stage s: valid, wr, rw, rdy. rdy = 0 for non-loads and LOAD_RDY for loads.
- A separate EX-source record holds rs, rt, rs_used and rt_used of the instruction now in EX.
- Match(s, r) = valid[s] & wr[s] & (rw[s] == r) & (r != 0) & used. The youngest (lowest s) match wins.
- Forward-select encoding: 0 = register file or pipeline value; s+1 = result of stage s.
- id_fwd: for the youngest match s with s ≥ rdy[s], select s+1; with no match, select 0.
- ex_fwd: search stages 1..DEPTH-1 only, using the EX-source record. Apply the same readiness rule.
- stall = id_valid & (any used source hits a youngest match s where either condition holds):
  - branch: s < rdy[s]
  - non-branch: s+1 < rdy[s]
- bubble = stall.
- if_flush = id_valid & id_is_branch & br_taken & ~stall. Stall has priority over flush.
- Per clock, the scoreboard shifts s → s+1 and the entry at DEPTH-1 retires.
  - Stage 0 loads the ID instruction when ~stall, otherwise an invalid entry.
  - The EX-source record loads the ID sources when ~stall, otherwise it is cleared (used = 0).
- stall_cnt increments each cycle stall = 1 and saturates at all-ones.
- All outputs except stall_cnt are combinational from state and ID inputs.

## Timing
- Reset (rst = 0, asynchronous): all valid bits, the EX-source record and stall_cnt go to 0. Every output reads 0 while rst is asserted. Reset mid-stall drops the stall immediately.
- stall, bubble, if_flush and all fwd outputs are valid in the same cycle as the ID inputs. Latency 0.
- Load-use with defaults: a non-branch consumer stalls 1 cycle; a branch consumer stalls 2 cycles.
- stall_cnt is updated at the clock edge following each stall cycle.
- A write to r0 never causes a stall or forward.
- Simultaneous matches in several stages: the youngest stage wins.

## Structure
- Shared package core_pkg:
  - FW select constants: FWD_RF = 0 and FWD_STAGE(s) = s+1
  - the scoreboard entry struct (valid, wr, rw, rdy)
- One sub-module, hz_match, used four times (ID a/b, EX a/b):
  - inputs: scoreboard vector, register address, used flag, lowest searchable stage
  - outputs: hit, select, not_ready

## Test plan
1. add r3 followed by add r4,r3,r1 -> no stall; next cycle ex_fwd_a = 2 (MEM).
2. lw r5 followed by add r6,r5,r5 -> stall = bubble = 1 for exactly 1 cycle; then ex_fwd_a = ex_fwd_b = 3; stall_cnt = 1.
3. add r7 followed by beq r7,r0 -> no stall; id_fwd_a = 1. Then lw r8 followed by beq r8,r0 -> 2 stall cycles, then id_fwd_a = 3.
4. addi r0,r0,5 followed by add r1,r0,r0 -> all fwd = 0, stall = 0.
5. Taken beq with no hazard -> if_flush = 1 for one cycle. Taken beq while stalled on lw -> if_flush = 0 until the stall clears, then 1.
6. rst asserted during a lw stall -> stall, all fwd and stall_cnt = 0 immediately; the next instruction after release proceeds without stall.
